// File: rtl/xmem_pkg.sv
// Shared types and sizes for the X-memory read streamer.
//   ADDR_W    : memory address width (depth = 2**ADDR_W)
//   DATA_W    : memory word width
//   LEN_W     : burst length width, wide enough to hold a full-memory burst
//   MEM_DEPTH : number of words in the memory
package xmem_pkg;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LEN_W     = 12;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE_ST
  } state_e;

  // One buffered stream beat: data word plus end-of-burst marker.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } xmem_word_t;

endpackage

// File: rtl/xmem_rd_streamer_if.sv
// Memory read port and output stream of the X-memory read streamer.
//   mem_cen/mem_wen/mem_a : chip enable (active low), write enable, address to memory
//   mem_q                 : read data from memory, one cycle after the sampling edge
//   out_data/out_valid/out_last/out_ready : valid/ready output stream
// master = streamer side, slave = memory + downstream consumer side.
interface xmem_rd_streamer_if;
  import xmem_pkg::*;

  logic              mem_cen;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output mem_cen, mem_wen, mem_a, out_data, out_valid, out_last,
    input  mem_q, out_ready
  );

  modport slave (
    input  mem_cen, mem_wen, mem_a, out_data, out_valid, out_last,
    output mem_q, out_ready
  );

endinterface

// File: rtl/xmem_rd_skid_fifo.sv
// Two-entry FIFO of {last, data} beats; entry 0 is always the head.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push_i        : write push_data_i at the edge
//   pop_i         : drop the head at the edge (ignored when empty)
//   count_o       : occupancy 0..2
//   head_o        : current head entry
module xmem_rd_skid_fifo
  import xmem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  xmem_word_t push_data_i,
  input  logic       pop_i,
  output logic [1:0] count_o,
  output xmem_word_t head_o
);

  xmem_word_t e0_q;
  xmem_word_t e1_q;
  logic [1:0] count_q;
  logic       do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign count_o = count_q;
  assign head_o  = e0_q;

  // Shift-register storage: a pop moves entry 1 into the head slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push_i, do_pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_q <= push_data_i;
          end else if (count_q == 2'd1) begin
            e1_q <= push_data_i;
          end
          if (count_q != 2'd2) begin
            count_q <= count_q + 2'd1;
          end
        end
        2'b01: begin
          e0_q    <= e1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and push: occupancy is unchanged.
          if (count_q == 2'd1) begin
            e0_q <= push_data_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/xmem_rd_streamer.sv
// Burst read initiator for one X-memory port: on start_i, reads len_i words
// from base_i (address wraps at the memory depth) and streams them in order.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : one-cycle burst request, only honoured when idle
//   base_i/len_i : first address / word count (0 completes immediately)
//   busy_o       : burst in progress
//   done_o       : one-cycle completion pulse
//   xm           : memory read port and output stream
module xmem_rd_streamer
  import xmem_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  busy_o,
  output logic                  done_o,
  xmem_rd_streamer_if.master    xm
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [LEN_W-1:0]  to_pop_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              busy_q;
  logic              done_q;

  logic [1:0]        fifo_count;
  xmem_word_t        fifo_head;
  xmem_word_t        fifo_push_data;
  logic [2:0]        occupancy;
  logic              pop;
  logic              issue;

  // Credit check: a read may issue only if the FIFO can hold it once every
  // outstanding word lands, counting the pop happening this cycle.
  assign pop       = xm.out_valid && xm.out_ready;
  assign occupancy = 3'(fifo_count) + 3'(inflight_q);
  assign issue     = (state_q == ISSUE) && (remaining_q != '0) &&
                     (occupancy < (3'd2 + 3'(pop)));

  assign xm.mem_cen = ~issue;
  assign xm.mem_wen = 1'b1;
  assign xm.mem_a   = addr_q;

  assign fifo_push_data = '{last: inflight_last_q, data: xm.mem_q};

  xmem_rd_skid_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight_q),
    .push_data_i (fifo_push_data),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (fifo_head)
  );

  assign xm.out_valid = (fifo_count != 2'd0);
  assign xm.out_data  = fifo_head.data;
  assign xm.out_last  = fifo_head.last && (fifo_count != 2'd0);

  assign busy_o = busy_q;
  assign done_o = done_q;

  // Burst FSM, counters and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      to_pop_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      // Read data arrives one cycle after the issuing edge.
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == LEN_W'(1));
      done_q          <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              addr_q      <= base_i;
              remaining_q <= len_i;
              to_pop_q    <= len_i;
              busy_q      <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE_ST;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              state_q <= DRAIN;
            end
          end
          if (pop) begin
            to_pop_q <= to_pop_q - LEN_W'(1);
          end
        end
        DRAIN: begin
          if (pop) begin
            to_pop_q <= to_pop_q - LEN_W'(1);
            if (to_pop_q == LEN_W'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE_ST;
            end
          end
        end
        DONE_ST: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xmem_rd_streamer.sv
// Self-checking bench for xmem_rd_streamer: behavioural memory, a queue-based
// expectation model of each burst, a per-cycle compare process, directed
// scenarios with literal expectations and randomized bursts.
module tb_xmem_rd_streamer;
  import xmem_pkg::*;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base  = '0;
  logic [LEN_W-1:0]  len   = '0;
  logic              busy;
  logic              done;

  xmem_rd_streamer_if xm ();

  xmem_rd_streamer dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .base_i  (base),
    .len_i   (len),
    .busy_o  (busy),
    .done_o  (done),
    .xm      (xm)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous-read memory.
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] q_r = '0;
  initial begin
    for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] = DATA_W'(i * 3);
  end
  always @(posedge clk) if (!xm.mem_cen) q_r <= mem[xm.mem_a];
  assign xm.mem_q = q_r;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  // Downstream ready: 0 = always, 1 = random, 2 = repeating 1,0,0,1,0,1.
  int       ready_mode = 0;
  int       pat_i      = 0;
  logic [5:0] pat      = 6'b101001;
  initial begin
    xm.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       xm.out_ready = 1'b1;
        1:       xm.out_ready = 1'($urandom_range(0, 1));
        default: begin
          xm.out_ready = pat[pat_i];
          pat_i = (pat_i + 1) % 6;
        end
      endcase
    end
  end

  // Expectation model: the list of words a burst must deliver.
  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
  } word_t;

  word_t             exp_q[$];
  int                n_issued = 0;
  int                n_popped = 0;
  int                b_len    = 0;
  int                b_base   = 0;
  bit                active   = 0;
  bit                log_en   = 0;
  int                addr_log[$];
  logic [DATA_W-1:0] last_pop_data = '0;
  logic              last_pop_last = 1'b0;

  bit                pv = 0, pr = 0, pl = 0;
  logic [DATA_W-1:0] pd = '0;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int  occ;
    bit  popping;
    if (rst) begin
      exp_q.delete();
      active = 0;
      pv = 0;
    end else begin
      popping = xm.out_valid && xm.out_ready;
      check("mem_wen", xm.mem_wen, 1);
      if (!xm.mem_cen) begin
        check("issue_in_burst", int'(active && (n_issued < b_len)), 1);
        check("mem_a", xm.mem_a, (b_base + n_issued) % int'(MEM_DEPTH));
        if (log_en) addr_log.push_back(int'(xm.mem_a));
      end
      occ = n_issued + (xm.mem_cen ? 0 : 1) - n_popped - (popping ? 1 : 0);
      check("outstanding_le_2", int'(occ <= 2), 1);
      if (pv && !pr) begin
        check("stall_valid", xm.out_valid, 1);
        check("stall_data", xm.out_data, pd);
        check("stall_last", xm.out_last, pl);
      end
      if (xm.out_valid) begin
        check("valid_has_word", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("out_data", xm.out_data, exp_q[0].d);
          check("out_last", xm.out_last, exp_q[0].l);
          if (popping) begin
            last_pop_data = xm.out_data;
            last_pop_last = xm.out_last;
            void'(exp_q.pop_front());
            n_popped++;
          end
        end
      end
      if (!xm.mem_cen) n_issued++;
      if (!active) check("busy_idle", busy, 0);
      else if (n_issued > 0 && !done) check("busy_mid", busy, 1);
      if (done) begin
        check("done_expected", active, 1);
        check("done_all_popped", exp_q.size(), 0);
        check("done_all_issued", n_issued, b_len);
        check("busy_low_at_done", busy, 0);
        active = 0;
      end
      pv = xm.out_valid;
      pr = xm.out_ready;
      pd = xm.out_data;
      pl = xm.out_last;
    end
  end

  // Issue START for a burst and load the model; returns #1 after the START edge.
  task automatic start_burst(input int b, input int l);
    word_t w;
    @(posedge clk);
    #1;
    start    = 1'b1;
    base     = ADDR_W'(b);
    len      = LEN_W'(l);
    b_base   = b;
    b_len    = l;
    n_issued = 0;
    n_popped = 0;
    active   = 1;
    exp_q.delete();
    for (int k = 0; k < l; k++) begin
      w.d = mem[(b + k) % int'(MEM_DEPTH)];
      w.l = (k == l - 1);
      exp_q.push_back(w);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    bit ok;
    ok  = 0;
    cyc = 0;
    while (cyc < budget && !ok) begin
      @(negedge clk);
      cyc++;
      if (done) ok = 1;
    end
    check("done_timeout", ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int b, l;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cen", xm.mem_cen, 1);
    check("rst_wen", xm.mem_wen, 1);
    check("rst_mem_a", xm.mem_a, 0);
    check("rst_valid", xm.out_valid, 0);
    check("rst_last", xm.out_last, 0);
    check("rst_data", xm.out_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic burst, literal timing and data.
    ready_mode = 0;
    start_burst(5, 4);
    @(negedge clk);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_cen", xm.mem_cen, 0);
    check("t1_c1_a", xm.mem_a, 5);
    check("t1_c1_valid", xm.out_valid, 0);
    @(negedge clk);
    check("t1_c2_valid", xm.out_valid, 0);
    @(negedge clk);
    check("t1_w0_valid", xm.out_valid, 1);
    check("t1_w0_data", xm.out_data, 15);
    check("t1_w0_last", xm.out_last, 0);
    @(negedge clk);
    check("t1_w1_data", xm.out_data, 18);
    check("t1_w1_last", xm.out_last, 0);
    @(negedge clk);
    check("t1_w2_data", xm.out_data, 21);
    @(negedge clk);
    check("t1_w3_data", xm.out_data, 24);
    check("t1_w3_last", xm.out_last, 1);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_busy_off", busy, 0);
    check("t1_valid_off", xm.out_valid, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // Address wrap.
    addr_log.delete();
    log_en = 1;
    start_burst(2046, 4);
    wait_done(50, cyc);
    log_en = 0;
    check("wrap_cycles", cyc, 7);
    check("wrap_n", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check("wrap_a0", addr_log[0], 2046);
      check("wrap_a1", addr_log[1], 2047);
      check("wrap_a2", addr_log[2], 0);
      check("wrap_a3", addr_log[3], 1);
    end
    check("wrap_last_data", last_pop_data, 3);

    // Backpressure pattern.
    ready_mode = 2;
    pat_i = 0;
    start_burst(300, 6);
    wait_done(100, cyc);
    check("bp_last_data", last_pop_data, 305 * 3);
    check("bp_last_flag", last_pop_last, 1);

    // Zero-length burst.
    ready_mode = 0;
    start_burst(77, 0);
    @(negedge clk);
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    check("z_cen", xm.mem_cen, 1);
    check("z_valid", xm.out_valid, 0);
    @(negedge clk);
    check("z_done_pulse", done, 0);

    // Whole-memory burst.
    start_burst(100, 2048);
    wait_done(2200, cyc);
    check("full_cycles", cyc, 2051);
    check("full_last_data", last_pop_data, 99 * 3);
    check("full_last_flag", last_pop_last, 1);

    // Reset in the middle of a burst.
    start_burst(500, 10);
    repeat (5) @(posedge clk);
    #1;
    check("mid_pops", n_popped, 3);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_valid", xm.out_valid, 0);
    check("mid_cen", xm.mem_cen, 1);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      check("mid_no_done", done, 0);
    end
    start_burst(0, 2);
    wait_done(20, cyc);
    check("post_rst_cycles", cyc, 5);
    check("post_rst_last", last_pop_data, 3);

    // Randomized bursts, with a START while busy that must be ignored.
    for (int t = 0; t < 25; t++) begin
      ready_mode = $urandom_range(0, 2);
      b = $urandom_range(0, 2047);
      l = $urandom_range(0, 40);
      start_burst(b, l);
      if (l > 0) begin
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = ADDR_W'($urandom_range(0, 2047));
        len   = LEN_W'($urandom_range(1, 50));
        @(posedge clk);
        #1 start = 1'b0;
      end
      wait_done(600, cyc);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xmem_rd_streamer.md
Name: xmem_rd_streamer

Overview:
- Read initiator for one port of the 2048x32 X memory.
- On START, issues a burst of LEN sequential reads beginning at BASE; address wraps modulo 2048.
- Returns the words in order on a valid/ready stream, with registered outputs and a 2-entry skid FIFO.
- Sits between the memory and the distance-compute datapath. It is the read-side counterpart to the memory's port (CEN/WEN/A in, Q out).

Parameters:
- ADDR_W, 11: memory address width; depth = 2**ADDR_W.
- DATA_W, 32: word width.
- LEN_W, 12: burst-length width; must represent 2**ADDR_W.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle burst request; sampled only in IDLE.
- BASE  in  ADDR_W  first address; sampled with START.
- LEN  in  LEN_W  number of words, 0..2048; sampled with START.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse after the last word handshakes (or immediately for LEN=0).
- MEM_CEN  out  1  active-low chip enable to memory port.
- MEM_WEN  out  1  constant 1 (read-only initiator).
- MEM_A  out  ADDR_W  read address.
- MEM_Q  in  DATA_W  memory read data, valid in the cycle after the edge that sampled a read.
- OUT_DATA  out  DATA_W  registered stream data.
- OUT_VALID  out  1  stream valid.
- OUT_LAST  out  1  marks the final word of the burst; qualified by OUT_VALID.
- OUT_READY  in  1  downstream ready.

Behaviour:
- Reset values: BUSY=0, DONE=0, MEM_CEN=1, MEM_WEN=1, MEM_A=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0. FIFO is emptied, the counters are cleared, and the FSM goes to IDLE.
- Reset mid-burst: same as above. An in-flight read is discarded (never captured), and no DONE is produced.
- FSM states:
  - IDLE: START=1 with LEN>0 -> ISSUE. Latch addr=BASE, remaining=LEN, to_pop=LEN. START=1 with LEN=0 -> DONE_ST.
  - ISSUE: a read is issued in a cycle when remaining>0 and (fifo_count + inflight - pop) < 2, where pop = OUT_VALID & OUT_READY.
    - Issue drives MEM_CEN=0, MEM_A=addr.
    - At the edge: addr <= addr+1 (wraps 2047->0), remaining--, inflight <= 1.
    - If no read is issued in a cycle: MEM_CEN=1 and inflight <= 0.
    - ISSUE -> DRAIN when remaining reaches 0.
  - DRAIN: no issues. DRAIN -> DONE_ST when to_pop reaches 0 (pop of the last word).
  - DONE_ST: DONE=1 for exactly one cycle, BUSY=0, then -> IDLE.
- MEM_CEN and MEM_A are combinational from state and counters (registered sources only; no path from OUT_READY except the pop term).
- Capture: if inflight=1, MEM_Q is written into the FIFO at the next edge. The credit rule makes FIFO overflow impossible.
- Stream rules:
  - OUT_VALID = FIFO non-empty; OUT_DATA/OUT_LAST come from the FIFO head.
  - OUT_LAST is set on the entry whose read was the final issue (remaining was 1).
  - Data must stay stable while OUT_VALID && !OUT_READY.
- Throughput and latency:
  - 1 word/cycle sustained with OUT_READY held high.
  - START sampled at edge 0 -> first MEM_CEN low is sampled at edge 1 -> first OUT_VALID after edge 2.
- Backpressure: with OUT_READY=0, at most 2 words are buffered. MEM_CEN stays 1 thereafter, so the memory's registered address is not disturbed.
- START while BUSY is ignored.
- A simultaneous pop and capture in the same cycle keeps the FIFO count unchanged.

Decomposition:
- Package xmem_pkg: ADDR_W, DATA_W, LEN_W, MEM_DEPTH, and the FSM state enum {IDLE, ISSUE, DRAIN, DONE_ST}.
- Sub-module xmem_rd_skid_fifo: 2-entry FIFO of {last, data}, synchronous reset, push/pop/count/head outputs.
- Top contains the FSM, counters, and credit logic.

Test Plan:
- Mem preloaded mem[i]=i*3. START with BASE=5, LEN=4, OUT_READY=1 -> OUT_DATA 15,18,21,24 on consecutive cycles; OUT_LAST only on 24; DONE the cycle after the last pop; first valid 2 cycles after START.
- Wrap-around: BASE=2046, LEN=4 -> MEM_A sequence 2046,2047,0,1; data mem[2046],mem[2047],mem[0],mem[1].
- Backpressure: LEN=6, OUT_READY toggles 1,0,0,1,0,1... -> no word lost or duplicated; MEM_CEN=1 whenever FIFO+inflight=2; OUT_DATA stable while stalled.
- LEN=0 START -> DONE pulses the cycle after START; MEM_CEN never low; OUT_VALID never high.
- LEN=2048, BASE=100, OUT_READY=1 -> 2048 words, last = mem[99]; exactly 2048 CEN-low cycles; BUSY falls with DONE.
- RESET asserted while a read is in flight (LEN=10, after 3 pops) -> next cycle: OUT_VALID=0, MEM_CEN=1, BUSY=0, no DONE. A following START with BASE=0, LEN=2 runs cleanly.
